// File: rtl/axistream_snooper.sv
// AXI-Stream snooper: copies each received packet into a packetmem buffer,
// one word per beat from address 0, then reports the length and whether the
// packet overflowed the buffer. Beats past the buffer end are still accepted
// (so the upstream is never wedged) but they are not written.
module axistream_snooper #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] TDATA,
    input  logic                  TVALID,
    input  logic                  TLAST,
    output logic                  TREADY,
    output logic [ADDR_WIDTH-1:0] snooper_wr_addr,
    output logic [DATA_WIDTH-1:0] snooper_wr_data,
    output logic                  snooper_wr_en,
    output logic                  snooper_done,
    output logic [ADDR_WIDTH:0]   len_from_snooper,
    output logic                  truncated,
    input  logic                  ready_for_snooper
);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH:0]   FULL_LEN  = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    tready_q, tready_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic                    trunc_q, trunc_d;
    logic                    accept;

    assign accept = TVALID && tready_q;

    // Next-state, write-port and completion-report logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        len_d     = len_q;
        trunc_d   = trunc_q;
        case (state_q)
            IDLE: begin
                // The done cycle is skipped so the packetmem has a chance to
                // drop ready for the buffer that was just filled.
                if (ready_for_snooper && !done_q) begin
                    state_d = RECV;
                    cnt_d   = '0;
                end
            end
            RECV: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = TDATA;
                    cnt_d     = cnt_q + 1'b1;
                    if (TLAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        len_d   = {1'b0, cnt_q} + (ADDR_WIDTH+1)'(1);
                        trunc_d = 1'b0;
                    end else if (cnt_q == LAST_ADDR) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && TLAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    len_d   = FULL_LEN;
                    trunc_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        tready_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tready_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            len_q     <= '0;
            trunc_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tready_q  <= tready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            len_q     <= len_d;
            trunc_q   <= trunc_d;
        end
    end

    assign TREADY           = tready_q;
    assign snooper_wr_en    = wr_en_q;
    assign snooper_wr_addr  = wr_addr_q;
    assign snooper_wr_data  = wr_data_q;
    assign snooper_done     = done_q;
    assign len_from_snooper = len_q;
    assign truncated        = trunc_q;

endmodule

// File: tb/tb_axistream_snooper.sv
// Bench for axistream_snooper with a 4-word buffer so overflow is easy to hit.
module tb_axistream_snooper;
    localparam int DW = 32;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] TDATA = '0;
    logic          TVALID = 1'b0;
    logic          TLAST = 1'b0;
    logic          TREADY;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          done;
    logic [AW:0]   len;
    logic          trunc;
    logic          ready = 1'b0;

    int checks = 0;
    int errors = 0;

    axistream_snooper #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .TDATA(TDATA), .TVALID(TVALID), .TLAST(TLAST),
        .TREADY(TREADY), .snooper_wr_addr(wr_addr), .snooper_wr_data(wr_data),
        .snooper_wr_en(wr_en), .snooper_done(done), .len_from_snooper(len),
        .truncated(trunc), .ready_for_snooper(ready)
    );

    always #5 clk = ~clk;

    // Observed packetmem writes and completion reports.
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    logic [AW:0]   dl_q[$];
    logic          dt_q[$];
    logic          dw_q[$];
    int            dbl = 0;
    logic          prev_done = 1'b0;
    bit            nopat[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (done === 1'b1) begin
            dl_q.push_back(len);
            dt_q.push_back(trunc);
            dw_q.push_back(wr_en);
            if (prev_done) dbl++;
        end
        prev_done = (done === 1'b1);
    end

    // Reference: the first DEPTH beats are stored, the rest only counted.
    function automatic int exp_len(input int n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); dl_q.delete(); dt_q.delete(); dw_q.delete();
    endtask

    // Offers beats d[0..stop_at-1]; vpat (if given) sets TVALID per TREADY cycle.
    task automatic drive(input logic [DW-1:0] d[$], input int stop_at, input bit rnd_rdy,
                         input int stall_pct, input bit vpat[$], output logic tr_after);
        int i = 0;
        int p = 0;
        int guard = 0;
        bit acc;
        while (i < stop_at && guard < 400) begin
            @(negedge clk);
            if (rnd_rdy) ready = 1'($urandom_range(1));
            if (TREADY) begin
                if (p < vpat.size()) TVALID = vpat[p];
                else TVALID = ($urandom_range(99) >= stall_pct);
                p++;
                TDATA = d[i];
                TLAST = (i == d.size() - 1);
            end else begin
                TVALID = 1'($urandom_range(1));
                TDATA  = $urandom;
                TLAST  = 1'($urandom_range(1));
            end
            acc = TVALID && TREADY;
            @(posedge clk);
            if (acc) i++;
            guard++;
        end
        @(negedge clk);
        TVALID = 1'b0;
        TLAST = 1'b0;
        tr_after = TREADY;
        if (rnd_rdy) ready = 1'b1;
        checks++;
        if (i < stop_at) begin
            errors++;
            $display("FAIL drive_timeout: accepted %0d beats, required %0d", i, stop_at);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({TREADY, wr_en, done, trunc} !== 4'b0 || len !== '0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: tready=%b wr_en=%b done=%b trunc=%b len=%0d addr=%0d data=%h, required all zero",
                     TREADY, wr_en, done, trunc, len, wr_addr, wr_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (TREADY !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_ready: tready=%b required 0", TREADY);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d[$] = '{32'hA, 32'hB, 32'hC};
        logic tr;
        clear_logs();
        ready = 1'b1;
        drive(d, 3, 1'b0, 0, nopat, tr);
        repeat (3) @(negedge clk);
        checks++;
        if (tr !== 1'b0) begin errors++; $display("FAIL basic_tready_after: got %b required 0", tr); end
        checks++;
        if (wa_q.size() != 3) begin errors++; $display("FAIL basic_nwrites: got %0d required 3", wa_q.size()); end
        for (int k = 0; k < 3 && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== AW'(k) || wd_q[k] !== d[k]) begin
                errors++;
                $display("FAIL basic_write%0d: addr=%0d data=%h required addr=%0d data=%h", k, wa_q[k], wd_q[k], k, d[k]);
            end
        end
        checks++;
        if (dl_q.size() != 1 || dl_q[0] !== 3'd3 || dt_q[0] !== 1'b0 || dw_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: ndone=%0d, required one done with len 3 trunc 0 alongside last write", dl_q.size());
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] d[$] = '{32'h55};
        logic tr;
        clear_logs();
        drive(d, 1, 1'b0, 0, nopat, tr);
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== 32'h55) begin
            errors++;
            $display("FAIL single_write: nwrites=%0d, required one write of 55 at addr 0", wa_q.size());
        end
        checks++;
        if (dl_q.size() != 1 || dl_q[0] !== 3'd1 || dt_q[0] !== 1'b0 || dw_q[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_done: ndone=%0d, required len 1 trunc 0 with the write", dl_q.size());
        end
    endtask

    task automatic test_truncate();
        logic [DW-1:0] d[$];
        logic tr;
        for (int k = 0; k < 6; k++) d.push_back($urandom);
        clear_logs();
        drive(d, 6, 1'b0, 0, nopat, tr);
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() != DEPTH) begin errors++; $display("FAIL trunc_nwrites: got %0d required %0d", wa_q.size(), DEPTH); end
        for (int k = 0; k < DEPTH && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== AW'(k) || wd_q[k] !== d[k]) begin
                errors++;
                $display("FAIL trunc_write%0d: addr=%0d data=%h required addr=%0d data=%h", k, wa_q[k], wd_q[k], k, d[k]);
            end
        end
        checks++;
        if (dl_q.size() != 1 || dl_q[0] !== 3'd4 || dt_q[0] !== 1'b1 || dw_q[0] !== 1'b0) begin
            errors++;
            $display("FAIL trunc_done: ndone=%0d, required len 4 trunc 1 without a write", dl_q.size());
        end
        checks++;
        if (len !== 3'd4 || trunc !== 1'b1) begin
            errors++;
            $display("FAIL trunc_hold: len=%0d trunc=%b required 4 1", len, trunc);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d[$];
        bit pat[$] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic tr;
        for (int k = 0; k < 3; k++) d.push_back($urandom);
        clear_logs();
        ready = 1'b1;
        drive(d, 3, 1'b0, 0, pat, tr);
        checks++;
        if (tr !== 1'b0) begin errors++; $display("FAIL stall_tready_done_cycle: got %b required 0", tr); end
        @(negedge clk);
        checks++;
        if (TREADY !== 1'b0) begin errors++; $display("FAIL stall_no_reentry: tready=%b required 0", TREADY); end
        @(negedge clk);
        checks++;
        if (TREADY !== 1'b1) begin errors++; $display("FAIL stall_reentry: tready=%b required 1", TREADY); end
        checks++;
        if (wa_q.size() != 3) begin errors++; $display("FAIL stall_nwrites: got %0d required 3", wa_q.size()); end
        for (int k = 0; k < 3 && k < wa_q.size(); k++) begin
            checks++;
            if (wa_q[k] !== AW'(k) || wd_q[k] !== d[k]) begin
                errors++;
                $display("FAIL stall_write%0d: addr=%0d data=%h required addr=%0d data=%h", k, wa_q[k], wd_q[k], k, d[k]);
            end
        end
        checks++;
        if (dl_q.size() != 1 || dl_q[0] !== 3'd3) begin errors++; $display("FAIL stall_done: ndone=%0d required one with len 3", dl_q.size()); end
        // Follow-on packet must restart at address 0.
        clear_logs();
        d = '{32'h1234, 32'h5678};
        drive(d, 2, 1'b0, 0, nopat, tr);
        repeat (2) @(negedge clk);
        checks++;
        if (wa_q.size() != 2 || wa_q[0] !== '0 || wd_q[0] !== 32'h1234 || dl_q.size() != 1 || dl_q[0] !== 3'd2) begin
            errors++;
            $display("FAIL stall_next_packet: nwrites=%0d ndone=%0d, required 2 writes from addr 0 and len 2", wa_q.size(), dl_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d[$];
        logic tr;
        for (int k = 0; k < 4; k++) d.push_back($urandom);
        clear_logs();
        drive(d, 2, 1'b0, 0, nopat, tr);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (TREADY !== 1'b0 || wr_en !== 1'b0 || len !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: tready=%b wr_en=%b len=%0d required 0 0 0", TREADY, wr_en, len);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wa_q.size() != 2 || dl_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_discard: nwrites=%0d ndone=%0d required 2 0", wa_q.size(), dl_q.size());
        end
        clear_logs();
        d = '{32'h77, 32'h88, 32'h99};
        drive(d, 3, 1'b0, 0, nopat, tr);
        repeat (2) @(negedge clk);
        checks++;
        if (wa_q.size() != 3 || wa_q[0] !== '0 || wd_q[2] !== 32'h99 || dl_q.size() != 1 || dl_q[0] !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_next_packet: nwrites=%0d ndone=%0d, required 3 writes from 0 and len 3", wa_q.size(), dl_q.size());
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] d[$];
        logic tr;
        int n;
        int m;
        for (int pk = 0; pk < 25; pk++) begin
            n = $urandom_range(7, 1);
            d.delete();
            for (int k = 0; k < n; k++) d.push_back($urandom);
            m = exp_len(n);
            clear_logs();
            drive(d, n, 1'b1, 35, nopat, tr);
            repeat (3) @(negedge clk);
            checks++;
            if (wa_q.size() != m) begin
                errors++;
                $display("FAIL rand%0d_nwrites: got %0d required %0d (n=%0d)", pk, wa_q.size(), m, n);
            end
            for (int k = 0; k < m && k < wa_q.size(); k++) begin
                checks++;
                if (wa_q[k] !== AW'(k) || wd_q[k] !== d[k]) begin
                    errors++;
                    $display("FAIL rand%0d_write%0d: addr=%0d data=%h required addr=%0d data=%h", pk, k, wa_q[k], wd_q[k], k, d[k]);
                end
            end
            checks++;
            if (dl_q.size() != 1 || dl_q[0] !== (AW+1)'(m) || dt_q[0] !== (n > DEPTH) || dw_q[0] !== (n <= DEPTH)) begin
                errors++;
                $display("FAIL rand%0d_done: ndone=%0d, required len %0d trunc %0d (n=%0d)", pk, dl_q.size(), m, n > DEPTH, n);
            end
        end
        checks++;
        if (dbl != 0) begin errors++; $display("FAIL done_back_to_back: got %0d double pulses required 0", dbl); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_truncate();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axistream_snooper.md
AXISTREAM_SNOOPER -- requirements
Module: axistream_snooper

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, width of stream beat and packetmem word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, packetmem word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port TDATA  input  DATA_WIDTH  AXI-Stream beat data.
REQ-006 SHALL have port TVALID  input  1  beat valid.
REQ-007 SHALL have port TLAST  input  1  final beat of packet.
REQ-008 SHALL have port TREADY  output  1  registered, beat accept.
REQ-009 SHALL have port snooper_wr_addr  output  ADDR_WIDTH  packetmem write word address.
REQ-010 SHALL have port snooper_wr_data  output  DATA_WIDTH  packetmem write data.
REQ-011 SHALL have port snooper_wr_en  output  1  packetmem write strobe.
REQ-012 SHALL have port snooper_done  output  1  one-cycle pulse, packet fully written.
REQ-013 SHALL have port len_from_snooper  output  ADDR_WIDTH+1  packet length in words, valid with snooper_done.
REQ-014 SHALL have port truncated  output  1  packet exceeded buffer, valid with snooper_done.
REQ-015 SHALL have port ready_for_snooper  input  1  packetmem has a free buffer.

Function
REQ-016 SHALL implement FSM states IDLE, RECV, DROP.
REQ-017 IDLE: TREADY=0; SHALL go to RECV when ready_for_snooper=1 and snooper_done=0 (blocks stale ready for one cycle after done).
REQ-018 RECV and DROP: TREADY=1; beat accepted on an edge where TVALID&&TREADY.
REQ-019 RECV: each accepted beat SHALL produce, in the following cycle, snooper_wr_en=1, snooper_wr_data=that TDATA, snooper_wr_addr=write counter; write counter then increments.
REQ-020 Write counter SHALL start at 0 for every packet; first beat written to address 0.
REQ-021 Accepted beat with TLAST=1 in RECV SHALL move FSM to IDLE; snooper_done=1 in the same cycle as that beat's write; len_from_snooper=beats written; truncated=0.
REQ-022 Accepted non-TLAST beat written to address 2^ADDR_WIDTH-1 SHALL move FSM to DROP.
REQ-023 DROP: accepted beats SHALL NOT write; accepted TLAST beat SHALL move FSM to IDLE and pulse snooper_done next cycle with len_from_snooper=2^ADDR_WIDTH, truncated=1.
REQ-024 Single-beat packet (TLAST on first beat) SHALL yield len_from_snooper=1.
REQ-025 TVALID=0 cycles in RECV/DROP SHALL stall without state or counter change; no write issued.
REQ-026 TDATA/TLAST SHALL be ignored whenever TREADY=0.
REQ-027 ready_for_snooper deasserting mid-packet SHALL NOT abort reception; sampled only in IDLE.
REQ-028 snooper_done SHALL never be high two consecutive cycles; len_from_snooper and truncated SHALL hold until next snooper_done.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, counter=0, TREADY=0, snooper_wr_en=0, snooper_done=0, truncated=0, len_from_snooper=0, snooper_wr_addr=0, snooper_wr_data=0.
REQ-030 rst mid-packet SHALL discard the partial packet with no snooper_done and no further writes.

Verification
REQ-031 ready_for_snooper=1, 3 beats 0xA,0xB,0xC (TLAST on 0xC), TVALID always high -> writes addr 0,1,2 data A,B,C; snooper_done with third write; len=3, truncated=0; TREADY low cycle after TLAST accepted.
REQ-032 Single beat 0x55 with TLAST -> one write addr 0, snooper_done same cycle, len=1.
REQ-033 ADDR_WIDTH=2, 6-beat packet -> writes addr 0..3 only, beats 5-6 accepted without write, done after TLAST, len=4, truncated=1.
REQ-034 TVALID toggling 1,0,0,1,1 (TLAST last) and ready held high through done -> 3 contiguous writes, no write on stall cycles, no RECV entry in done cycle, next packet starts at addr 0.
REQ-035 rst asserted after 2nd beat of 4 -> no done pulse, TREADY=0 next cycle, later packet writes from addr 0 with correct len.
